// File: rtl/demux1to8_32_buf_pkg.sv
// Shared sizes and helpers for the 1:8 buffered write demultiplexer.
package demux1to8_32_buf_pkg;
  localparam int WIDTH_DEF = 32;
  localparam int SEL_W     = 3;
  localparam int NCH       = 8;
  localparam int OCC_W     = 4;

  function automatic logic [OCC_W-1:0] popcount(input logic [NCH-1:0] v);
    logic [OCC_W-1:0] c;
    c = '0;
    for (int i = 0; i < NCH; i++) c = c + OCC_W'(v[i]);
    return c;
  endfunction
endpackage

// File: rtl/demux_slot_32.sv
// One channel of the demux: a holding register plus a valid flag.
module demux_slot_32
  import demux1to8_32_buf_pkg::*;
#(
  parameter int W = WIDTH_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         ack,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         valid
);

  // Load wins over ack so a same-cycle refill keeps the channel full;
  // ack leaves the data in place, only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      dout  <= din;
      valid <= 1'b1;
    end else if (ack) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux1to8_32_buf.sv
// Steers one word per cycle into one of eight acknowledge-released holding slots.
module demux1to8_32_buf
  import demux1to8_32_buf_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [SEL_W-1:0]     sel,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 in_ready,
  output logic [NCH*WIDTH-1:0] o_data,
  output logic [NCH-1:0]       o_valid,
  input  logic [NCH-1:0]       o_ack,
  output logic [OCC_W-1:0]     occ
);

  logic             accept;
  logic [NCH-1:0]   load;
  logic [NCH-1:0]   valid_next;

  assign in_ready = ~o_valid[sel] | o_ack[sel];
  assign accept   = in_valid & in_ready;
  assign load     = accept ? (NCH'(1) << sel) : '0;

  // Mirrors the slot update rule so occ lands on the same edge as o_valid.
  assign valid_next = load | (o_valid & ~o_ack);

  for (genvar i = 0; i < NCH; i++) begin : g_slot
    demux_slot_32 #(.W(WIDTH)) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load[i]),
      .ack   (o_ack[i]),
      .din   (in_data),
      .dout  (o_data[i*WIDTH +: WIDTH]),
      .valid (o_valid[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) occ <= '0;
    else        occ <= popcount(valid_next);
  end

endmodule
